// File: rtl/fc_loss_stage_if.sv
// fc_loss_stage_if: bundles the fc loss stage streams.
// in_*    : indexed Q16.16 forward values from the fc layer (valid/rdy)
// label*  : target class, latched on a single-cycle label_valid pulse
// out_*   : indexed Q16.16 error values to the fc backward pass (valid/rdy)
// pred_*  : argmax of the last complete vector; idx_err is sticky range error
interface fc_loss_stage_if #(
    parameter int IDX_W = 10
);
    logic [31:0]      in_data;
    logic [IDX_W-1:0] in_idx;
    logic             in_valid;
    logic             in_rdy;
    logic [IDX_W-1:0] label;
    logic             label_valid;
    logic [31:0]      out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_rdy;
    logic [IDX_W-1:0] pred_class;
    logic             pred_valid;
    logic             idx_err;

    modport slave (
        input  in_data, in_idx, in_valid, label, label_valid, out_rdy,
        output in_rdy, out_data, out_idx, out_valid, pred_class, pred_valid, idx_err
    );

    modport master (
        output in_data, in_idx, in_valid, label, label_valid, out_rdy,
        input  in_rdy, out_data, out_idx, out_valid, pred_class, pred_valid, idx_err
    );
endinterface

// File: rtl/fc_loss_stage.sv
// fc_loss_stage: buffers one fc output vector, reports its argmax and streams
// (output - one_hot(label)) >>> GRAD_SHIFT back, saturated to 32 bits.
// clk, rst : clock, synchronous active-high reset
// bus      : fc_loss_stage_if slave (input stream, label, error stream, prediction)
module fc_loss_stage #(
    parameter int N_OUT      = 10,
    parameter int IDX_W      = 10,
    parameter int GRAD_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst,
    fc_loss_stage_if.slave    bus
);
    localparam int CW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [1:0] {COLLECT, SCAN, WAIT_LABEL, EMIT} state_t;

    state_t             state_q;
    logic signed [31:0] buf_q [N_OUT];
    logic [N_OUT-1:0]   recv_q;
    logic signed [31:0] max_val_q;
    logic [CW-1:0]      max_idx_q;
    logic               max_ok_q;
    logic               dup_q;
    logic [IDX_W-1:0]   label_q;
    logic               label_ok_q;
    logic [CW-1:0]      i_q;
    logic               in_rdy_q;
    logic               out_valid_q;
    logic [31:0]        out_data_q;
    logic [IDX_W-1:0]   out_idx_q;
    logic [IDX_W-1:0]   pred_class_q;
    logic               pred_valid_q;
    logic               idx_err_q;

    logic               acc_d;
    logic               in_range_d;
    logic [CW-1:0]      widx_d;
    logic [N_OUT-1:0]   recv_d;
    logic               take_d;
    logic               scan_take_d;
    logic               label_now_d;
    logic [CW-1:0]      ni_d;
    logic signed [32:0] diff_d;
    logic signed [32:0] sh_d;
    logic [31:0]        err_d;

    assign acc_d       = bus.in_valid && in_rdy_q;
    assign in_range_d  = bus.in_idx < IDX_W'(N_OUT);
    assign widx_d      = bus.in_idx[CW-1:0];
    assign recv_d      = recv_q | (N_OUT'(1) << widx_d);
    // Ties go to the lower index regardless of arrival order.
    assign take_d      = !max_ok_q || ($signed(bus.in_data) > max_val_q) ||
                         (($signed(bus.in_data) == max_val_q) && (widx_d < max_idx_q));
    assign scan_take_d = (i_q == '0) || (buf_q[i_q] > max_val_q);
    // A label pulse coinciding with completion counts as already latched.
    assign label_now_d = label_ok_q || bus.label_valid;
    // Index of the value loaded into the output register this cycle.
    assign ni_d        = out_valid_q ? i_q + 1'b1 : i_q;
    assign diff_d      = {buf_q[ni_d][31], buf_q[ni_d]} -
                         ((IDX_W'(ni_d) == label_q) ? 33'sh0_0001_0000 : 33'sh0);
    assign sh_d        = diff_d >>> GRAD_SHIFT;
    // Overflow when the two top bits disagree after the 33-bit subtract/shift.
    assign err_d       = (sh_d[32] != sh_d[31]) ? (sh_d[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                                                : sh_d[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            recv_q       <= '0;
            max_val_q    <= '0;
            max_idx_q    <= '0;
            max_ok_q     <= 1'b0;
            dup_q        <= 1'b0;
            label_q      <= '0;
            label_ok_q   <= 1'b0;
            i_q          <= '0;
            in_rdy_q     <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_idx_q    <= '0;
            pred_class_q <= '0;
            pred_valid_q <= 1'b0;
            idx_err_q    <= 1'b0;
        end else begin
            if (bus.label_valid && state_q != EMIT) begin
                label_q    <= bus.label;
                label_ok_q <= 1'b1;
                if (bus.label >= IDX_W'(N_OUT)) idx_err_q <= 1'b1;
            end
            case (state_q)
                COLLECT: begin
                    if (acc_d) begin
                        pred_valid_q <= 1'b0;
                        if (in_range_d) begin
                            buf_q[widx_d] <= bus.in_data;
                            recv_q        <= recv_d;
                            if (recv_q[widx_d]) dup_q <= 1'b1;
                            if (take_d) begin
                                max_val_q <= bus.in_data;
                                max_idx_q <= widx_d;
                                max_ok_q  <= 1'b1;
                            end
                            // Stop accepting as soon as the vector is complete.
                            if (&recv_d) in_rdy_q <= 1'b0;
                        end else begin
                            idx_err_q <= 1'b1;
                        end
                    end
                    if (&recv_q) begin
                        i_q <= '0;
                        if (dup_q) begin
                            // An overwrite may have lowered the running max: rescan.
                            state_q <= SCAN;
                        end else begin
                            pred_class_q <= IDX_W'(max_idx_q);
                            pred_valid_q <= 1'b1;
                            state_q      <= label_now_d ? EMIT : WAIT_LABEL;
                        end
                    end
                end
                SCAN: begin
                    if (scan_take_d) begin
                        max_val_q <= buf_q[i_q];
                        max_idx_q <= i_q;
                    end
                    if (i_q == CW'(N_OUT - 1)) begin
                        pred_class_q <= IDX_W'(scan_take_d ? i_q : max_idx_q);
                        pred_valid_q <= 1'b1;
                        i_q          <= '0;
                        state_q      <= label_now_d ? EMIT : WAIT_LABEL;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                WAIT_LABEL: begin
                    if (bus.label_valid) state_q <= EMIT;
                end
                EMIT: begin
                    if (!out_valid_q || bus.out_rdy) begin
                        if (out_valid_q && i_q == CW'(N_OUT - 1)) begin
                            out_valid_q <= 1'b0;
                            recv_q      <= '0;
                            label_ok_q  <= 1'b0;
                            label_q     <= '0;
                            in_rdy_q    <= 1'b1;
                            max_ok_q    <= 1'b0;
                            dup_q       <= 1'b0;
                            i_q         <= '0;
                            state_q     <= COLLECT;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= err_d;
                            out_idx_q   <= IDX_W'(ni_d);
                            i_q         <= ni_d;
                        end
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.in_rdy     = in_rdy_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.pred_class = pred_class_q;
    assign bus.pred_valid = pred_valid_q;
    assign bus.idx_err    = idx_err_q;
endmodule

// File: tb/tb_fc_loss_stage.sv
// tb_fc_loss_stage: scoreboard bench for fc_loss_stage (GRAD_SHIFT 0 and 2 in lockstep).
module tb_fc_loss_stage;
    typedef struct {
        int          idx;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] vec [10];
    bit          hold [2];
    logic [9:0]  h_idx [2];
    logic [31:0] h_d [2];

    always #5 clk = ~clk;

    fc_loss_stage_if #(.IDX_W(10)) bus ();
    fc_loss_stage_if #(.IDX_W(10)) bus2 ();

    assign bus2.in_data     = bus.in_data;
    assign bus2.in_idx      = bus.in_idx;
    assign bus2.in_valid    = bus.in_valid;
    assign bus2.label       = bus.label;
    assign bus2.label_valid = bus.label_valid;
    assign bus2.out_rdy     = bus.out_rdy;

    fc_loss_stage #(.N_OUT(10), .IDX_W(10), .GRAD_SHIFT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus));
    fc_loss_stage #(.N_OUT(10), .IDX_W(10), .GRAD_SHIFT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    function automatic logic [31:0] ref_err(input logic [31:0] v, input bit hot, input int sh);
        longint e;
        longint mx;
        mx = 64'sd2147483647;
        e = longint'($signed(v));
        if (hot) e = e - 65536;
        e = e >>> sh;
        if (e > mx) return 32'h7FFF_FFFF;
        if (e < -mx - 1) return 32'h8000_0000;
        return e[31:0];
    endfunction

    function automatic int ref_argmax();
        int best = 0;
        for (int i = 1; i < 10; i++)
            if ($signed(vec[i]) > $signed(vec[best])) best = i;
        return best;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int lab);
        for (int i = 0; i < 10; i++) begin
            q0.push_back('{i, ref_err(vec[i], i == lab, 0)});
            q1.push_back('{i, ref_err(vec[i], i == lab, 2)});
        end
    endtask

    task automatic mon(input int w, input logic v, input logic r, input logic [9:0] idx, input logic [31:0] d);
        exp_t e;
        bit   got;
        if (rst) begin
            hold[w] = 1'b0;
            return;
        end
        if (hold[w]) begin
            total++;
            if (!v || idx != h_idx[w] || d != h_d[w]) begin
                bad++;
                $display("FAIL hold%0d actual v=%0d idx=%0d data=%h required idx=%0d data=%h",
                         w, v, idx, d, h_idx[w], h_d[w]);
            end
        end
        if (v && r) begin
            total++;
            got = 1'b0;
            if (w == 0 && q0.size() != 0) begin e = q0.pop_front(); got = 1'b1; end
            if (w == 1 && q1.size() != 0) begin e = q1.pop_front(); got = 1'b1; end
            if (!got) begin
                bad++;
                $display("FAIL out%0d unexpected actual idx=%0d data=%h required none", w, idx, d);
            end else if (int'(idx) != e.idx || d !== e.d) begin
                bad++;
                $display("FAIL out%0d actual idx=%0d data=%h required idx=%0d data=%h",
                         w, idx, d, e.idx, e.d);
            end
        end
        hold[w]  = v && !r;
        h_idx[w] = idx;
        h_d[w]   = d;
    endtask

    initial forever begin
        @(negedge clk);
        mon(0, bus.out_valid, bus.out_rdy, bus.out_idx, bus.out_data);
        mon(1, bus2.out_valid, bus2.out_rdy, bus2.out_idx, bus2.out_data);
    end

    task automatic send(input int idx, input logic [31:0] d);
        int n = 0;
        bus.in_idx   = idx[9:0];
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_rdy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_rdy_wait", {31'd0, bus.in_rdy}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_label(input int l);
        bus.label       = l[9:0];
        bus.label_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.label_valid = 1'b0;
    endtask

    task automatic wait_pred();
        int n = 0;
        while (!bus.pred_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pred_valid", {31'd0, bus.pred_valid}, 32'd1);
        chk("pred_valid2", {31'd0, bus2.pred_valid}, 32'd1);
    endtask

    task automatic wait_empty(input bit tog);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
            @(posedge clk);
            #1;
            if (tog) bus.out_rdy = ~bus.out_rdy;
            n++;
        end
        bus.out_rdy = 1'b1;
        chk("stream_left", q0.size() + q1.size(), 32'd0);
    endtask

    task automatic run_vec(input int lab, input bit early, input bit tog, input bit shuf,
                           input bit dup, input bit badi);
        int ord [10];
        int j;
        int t;
        int p;
        for (int i = 0; i < 10; i++) ord[i] = i;
        if (shuf)
            for (int i = 9; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                t = ord[i];
                ord[i] = ord[j];
                ord[j] = t;
            end
        push_exp(lab);
        p = ref_argmax();
        if (early) pulse_label(lab);
        if (dup) send(ord[3], 32'h7FFF_FFFF);
        for (int i = 0; i < 10; i++) begin
            send(ord[i], vec[ord[i]]);
            if (badi && i == 4) send(15, 32'h1234_5678);
        end
        wait_pred();
        chk("pred_class", {22'd0, bus.pred_class}, p);
        chk("pred_class2", {22'd0, bus2.pred_class}, p);
        chk("in_rdy_busy", {31'd0, bus.in_rdy}, 32'd0);
        if (!early) pulse_label(lab);
        wait_empty(tog);
        chk("in_rdy_done", {31'd0, bus.in_rdy}, 32'd1);
        chk("out_valid_done", {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_idx      = '0;
        bus.in_data     = '0;
        bus.label       = '0;
        bus.label_valid = 1'b0;
        bus.out_rdy     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_idx", {22'd0, bus.out_idx}, 32'd0);
        chk("rst_pred_class", {22'd0, bus.pred_class}, 32'd0);
        chk("rst_pred_valid", {31'd0, bus.pred_valid}, 32'd0);
        chk("rst_idx_err", {31'd0, bus.idx_err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) vec[i] = i << 16;
        run_vec(9, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) vec[i] = 32'h0002_0000;
        run_vec(3, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) vec[i] = $urandom;
        run_vec(int'($urandom_range(9, 0)), 0, 1, 0, 0, 0);

        for (int i = 0; i < 10; i++) vec[i] = 32'h0004_0000;
        vec[2] = 32'h8000_0000;
        run_vec(2, 0, 0, 0, 0, 0);
        chk("idx_err_clean", {31'd0, bus.idx_err}, 32'd0);

        for (int i = 0; i < 10; i++) vec[i] = $urandom;
        run_vec(int'($urandom_range(9, 0)), 0, 0, 1, 0, 1);
        chk("idx_err_set", {31'd0, bus.idx_err}, 32'd1);
        chk("idx_err_set2", {31'd0, bus2.idx_err}, 32'd1);

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 10; i++)
                vec[i] = ($urandom_range(3, 0) == 0) ? 32'h0003_0000 : $urandom;
            run_vec(int'($urandom_range(9, 0)), $urandom_range(1, 0) == 1,
                    $urandom_range(1, 0) == 1, 1, $urandom_range(1, 0) == 1, 0);
        end

        for (int i = 0; i < 10; i++) vec[i] = $urandom;
        run_vec(12, 0, 0, 1, 0, 0);

        for (int i = 0; i < 10; i++) vec[i] = $urandom;
        push_exp(5);
        for (int i = 0; i < 10; i++) send(i, vec[i]);
        pulse_label(5);
        n = 0;
        while (!(bus.out_valid && bus.out_idx == 10'd4) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("emit_idx4_seen", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mid_out_valid2", {31'd0, bus2.out_valid}, 32'd0);
        chk("rst_mid_pred_valid", {31'd0, bus.pred_valid}, 32'd0);
        chk("rst_mid_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
        chk("rst_mid_idx_err", {31'd0, bus.idx_err}, 32'd0);
        q0.delete();
        q1.delete();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) vec[i] = $urandom;
        run_vec(int'($urandom_range(9, 0)), 0, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fc_loss_stage.md
Name: fc_loss_stage

Overview:
- Sits directly downstream of the fc layer and consumes its indexed Q16.16 output stream, one value per index.
- Buffers one full output vector and reports the predicted class (argmax).
- Once a target label is available, streams the error vector (output minus one-hot target, scaled) back, indexed, for the fc backward pass.
- Gives the fc layer a self-contained forward → loss → backward loop.

Parameters:
- N_OUT, 10, number of fc outputs per vector
- IDX_W, 10, width of index ports
- GRAD_SHIFT, 0, arithmetic right shift applied to every error value (learning-rate scaling)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_data  input  32  fc output value, signed Q16.16
- in_idx  input  IDX_W  index of in_data
- in_valid  input  1  in_data/in_idx valid
- in_rdy  output  1  block accepts input this cycle
- label  input  IDX_W  target class
- label_valid  input  1  pulse; latch label
- out_data  output  32  error value, signed Q16.16
- out_idx  output  IDX_W  index of out_data
- out_valid  output  1  out_data/out_idx valid
- out_rdy  input  1  downstream (fc backward) accepts output
- pred_class  output  IDX_W  argmax of last complete vector
- pred_valid  output  1  pred_class valid
- idx_err  output  1  sticky: out-of-range index received

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state COLLECT, in_rdy=1, out_valid=0, out_data=0, out_idx=0, pred_class=0, pred_valid=0, idx_err=0. Received bitmap is cleared, running max is cleared, and any latched label is discarded.
- Input handshake: a transfer occurs when in_valid && in_rdy.
  - in_idx < N_OUT: buf[in_idx] <= in_data and set recv[in_idx].
  - in_idx >= N_OUT: value dropped, idx_err <= 1 (cleared only by rst).
  - Duplicate index: overwrites buf and updates the max candidate. It does not count twice.
- Running argmax: updated on each accepted in-range value. Strictly-greater signed compare, so on ties the lowest index wins among equals. On a duplicate write, the max is recomputed at vector completion by a scan (the scan is allowed; it adds at most N_OUT cycles).
- State COLLECT: in_rdy=1. When all recv bits are set, the next cycle:
  - pred_class <= argmax, pred_valid <= 1.
  - in_rdy <= 0.
  - Go to WAIT_LABEL, or to EMIT if a label is already latched.
- label_valid: accepted in any state except EMIT; the latest pulse wins. label >= N_OUT treats the target as all-zero (no one-hot bit) and sets idx_err.
- State WAIT_LABEL: in_rdy=0; go to EMIT on the cycle after label_valid.
- State EMIT: i counts 0..N_OUT-1.
  - out_valid=1, out_idx=i.
  - out_data = sat32((buf[i] - (i==label ? 32'h0001_0000 : 0)) >>> GRAD_SHIFT). The subtract is done at 33 bits and saturates to 0x7FFFFFFF / 0x80000000.
  - out_data/out_idx hold stable while out_valid && !out_rdy.
  - On out_rdy, i advances the next cycle.
  - After the transfer of index N_OUT-1: out_valid <= 0, clear recv, clear the latched label, in_rdy <= 1, go to COLLECT.
- pred_valid stays 1 until the first accepted input of the next vector.
- Latency: first out_valid occurs 1 cycle after entering EMIT. With out_rdy held high, there is 1 value per cycle and the full vector takes N_OUT cycles.
- Simultaneous events:
  - Completion in the same cycle as label_valid: the label is taken and the block goes to EMIT.
  - rst has priority over everything; rst mid-EMIT aborts the stream with out_valid=0 the next cycle.

Test Plan:
1. Reset, then feed idx 0..9 with value idx*1.0 (0x000i0000), then label=9 → pred_class=9, pred_valid=1, in_rdy=0. Outputs are 0x00000000, 0x00010000 … 0x00080000 for idx 0..8, and idx 9 = 0x00080000.
2. Equal values 0x00020000 at all indices, label=3 → pred_class=0. out_data[3]=0x00010000, all others 0x00020000.
3. out_rdy toggled 1/0 every cycle during EMIT → each index is held while out_rdy=0, no index skipped or repeated, 10 transfers total.
4. in_data=0x80000000 at idx 2, label=2 → out_data[2]=0x80000000 (saturated). With GRAD_SHIFT=2 and buf=0x00040000, the non-label output is 0x00010000.
5. in_idx=15 injected mid-vector → value dropped, idx_err=1; the vector completes normally after the remaining valid indices.
6. Assert rst during EMIT at idx 4 → next cycle out_valid=0, pred_valid=0, in_rdy=1. A fresh vector plus label produces a full 10-value stream starting at idx 0.
